matrix_stream_loader: RTL
=========================

MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

Interface
REQ-001 Parameter DATA_W, default 4: element and header word width; SHALL be >= clog2(MAX_DIM+1).
REQ-002 Parameter MAX_DIM, default 4: maximum rows or columns of either matrix.
REQ-003 CLK  in  1  single clock; all logic updates on the posedge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse; leaves DONE or ERR for HDR.
REQ-006 in_valid  in  1  in_data/in_hdr carry a word this cycle.
REQ-007 in_data  in  DATA_W  header dimension or matrix element.
REQ-008 in_hdr  in  1  1 = header word, 0 = element word.
REQ-009 in_ready  out  1  loader accepts a word this cycle.
REQ-010 R1, C1, R2, C2  out  clog2(MAX_DIM+1) each  latched dimensions.
REQ-011 rd_sel  in  1  read-port matrix select: 0 = matrix_1, 1 = matrix_2.
REQ-012 rd_row, rd_col  in  clog2(MAX_DIM) each  read-port element index.
REQ-013 rd_data  out  DATA_W  combinational read of the selected element.
REQ-014 done  out  1  level, high in DONE.
REQ-015 err  out  1  level, high in ERR.

Function
REQ-016 States: HDR, LD1, LD2, DONE, ERR; a transfer occurs when in_valid && in_ready.
REQ-017 in_ready SHALL be 1 in HDR, LD1 and LD2, and 0 in DONE and ERR.
REQ-018 HDR: the 1st through 4th transferred words latch R1, C1, R2, C2 in that order; the 4th word moves the FSM to LD1.
REQ-019 A header word with value 0 or > MAX_DIM SHALL move the FSM to ERR; the offending value is not latched.
REQ-020 A transfer with in_hdr = 0 in HDR, or in_hdr = 1 in LD1/LD2, SHALL move the FSM to ERR.
REQ-021 LD1: R1*C1 elements are stored row-major into matrix_1 (column index wraps at C1, then row increments); the last element moves the FSM to LD2.
REQ-022 LD2: R2*C2 elements are stored likewise into matrix_2; the last element moves the FSM to DONE.
REQ-023 done SHALL rise on the cycle after the final element transfer; no word is accepted while done is high.
REQ-024 Cycles with in_valid = 0 SHALL NOT advance any index (bubbles allowed anywhere).
REQ-025 rd_data SHALL return the stored element when rd_row < Rn and rd_col < Cn of the selected matrix, else 0; it is valid in every state.
REQ-026 start in DONE or ERR SHALL clear the dimensions, indices, done and err, and enter HDR next cycle; matrix contents are retained.
REQ-027 start in HDR, LD1 or LD2 SHALL be ignored.
REQ-028 RST has priority over start and over any transfer in the same cycle.

Reset
REQ-029 On RST: state = HDR, in_ready = 1, done = 0, err = 0, R1 = C1 = R2 = C2 = 0, all indices = 0, all matrix storage = 0.
REQ-030 RST asserted mid-load SHALL discard the partial load; the first word accepted after RST is header word 1.

Configuration
REQ-031 Macro MATRIX_LOADER_MULCHECK_EN defined: on the 4th header word, if C1 != R2 the FSM SHALL enter ERR instead of LD1.
REQ-032 MATRIX_LOADER_MULCHECK_EN undefined: no C1/R2 compatibility check is made; any legal dimensions proceed to LD1.

Verification
REQ-033 Defaults; header 2,2,2,2 (in_hdr=1), then elements 1,15,2,3 and 4,5,6,7 -> done on the cycle after the 8th transfer; matrix_1[0][1] = 15; matrix_2[1][1] = 7; R1 = C1 = R2 = C2 = 2.
REQ-034 Header 2,0 -> err = 1 on the cycle after the 2nd word; in_ready = 0; R1 = 2, C1 = 0; start pulse -> HDR, err = 0.
REQ-035 MAX_DIM = 4, header 5 -> err = 1; a header of 3,1,1,4 followed by in_hdr = 1 during LD1 -> err = 1.
REQ-036 Header 2,2,2,2; in_valid toggling 1,0,1,0 during loading -> same final contents as REQ-033, done after 8 transfers.
REQ-037 RST after 3 elements of matrix_1 -> all outputs at reset values; a new full load then completes with correct contents.
REQ-038 Header 2,3,2,2: with MATRIX_LOADER_MULCHECK_EN -> err = 1 after the 4th word; without it -> LD1, and done after 10 elements.

Source files
------------

// File: rtl/matrix_stream_loader.sv
// Streams a 4-word dimension header and two row-major matrices into local storage.
// Optional MATRIX_LOADER_MULCHECK_EN rejects headers whose C1 != R2.
module matrix_stream_loader #(
  parameter  int DATA_W  = 4,
  parameter  int MAX_DIM = 4,
  localparam int DW      = $clog2(MAX_DIM + 1),
  localparam int IW      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_hdr,
  output logic              in_ready,
  output logic [DW-1:0]     R1,
  output logic [DW-1:0]     C1,
  output logic [DW-1:0]     R2,
  output logic [DW-1:0]     C2,
  input  logic              rd_sel,
  input  logic [IW-1:0]     rd_row,
  input  logic [IW-1:0]     rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_HDR, S_LD1, S_LD2, S_DONE, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [DW-1:0]     r1_q, r1_d, c1_q, c1_d, r2_q, r2_d, c2_q, c2_d;
  logic [DW-1:0]     row_q, row_d, col_q, col_d;
  logic [DATA_W-1:0] mat1_q [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] mat1_d [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] mat2_q [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] mat2_d [MAX_DIM][MAX_DIM];

  logic          xfer, hdr_ok, mul_ok, col_last, row_last;
  logic [DW-1:0] cur_r, cur_c, hdr_val;

  assign xfer     = in_valid && in_ready;
  assign hdr_ok   = (in_data != '0) && (in_data <= DATA_W'(MAX_DIM));
  assign hdr_val  = in_data[DW-1:0];
  assign cur_r    = (state_q == S_LD2) ? r2_q : r1_q;
  assign cur_c    = (state_q == S_LD2) ? c2_q : c1_q;
  assign col_last = (col_q == cur_c - DW'(1));
  assign row_last = (row_q == cur_r - DW'(1));

  // R2 is already latched when the 4th header word arrives, so the check uses flops only.
`ifdef MATRIX_LOADER_MULCHECK_EN
  assign mul_ok = (c1_q == r2_q);
`else
  assign mul_ok = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_HDR;
      hdr_cnt_q <= '0;
      r1_q      <= '0;
      c1_q      <= '0;
      r2_q      <= '0;
      c2_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      for (int i = 0; i < MAX_DIM; i++)
        for (int j = 0; j < MAX_DIM; j++) begin
          mat1_q[i][j] <= '0;
          mat2_q[i][j] <= '0;
        end
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      r1_q      <= r1_d;
      c1_q      <= c1_d;
      r2_q      <= r2_d;
      c2_q      <= c2_d;
      row_q     <= row_d;
      col_q     <= col_d;
      mat1_q    <= mat1_d;
      mat2_q    <= mat2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: if (xfer) begin
        if (!in_hdr || !hdr_ok)    state_d = S_ERR;
        else if (hdr_cnt_q == 2'd3) state_d = mul_ok ? S_LD1 : S_ERR;
      end
      S_LD1: if (xfer) begin
        if (in_hdr)                     state_d = S_ERR;
        else if (row_last && col_last)  state_d = S_LD2;
      end
      S_LD2: if (xfer) begin
        if (in_hdr)                     state_d = S_ERR;
        else if (row_last && col_last)  state_d = S_DONE;
      end
      S_DONE, S_ERR: if (start) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_HDR) || (state_q == S_LD1) || (state_q == S_LD2);
    done     = (state_q == S_DONE);
    err      = (state_q == S_ERR);
  end

  always_comb begin
    hdr_cnt_d = hdr_cnt_q;
    r1_d      = r1_q;
    c1_d      = c1_q;
    r2_d      = r2_q;
    c2_d      = c2_q;
    row_d     = row_q;
    col_d     = col_q;
    mat1_d    = mat1_q;
    mat2_d    = mat2_q;
    case (state_q)
      S_HDR: if (xfer && in_hdr && hdr_ok) begin
        case (hdr_cnt_q)
          2'd0:    r1_d = hdr_val;
          2'd1:    c1_d = hdr_val;
          2'd2:    r2_d = hdr_val;
          default: c2_d = hdr_val;
        endcase
        hdr_cnt_d = hdr_cnt_q + 2'd1;
      end
      S_LD1, S_LD2: if (xfer && !in_hdr) begin
        if (state_q == S_LD1) mat1_d[row_q[IW-1:0]][col_q[IW-1:0]] = in_data;
        else                  mat2_d[row_q[IW-1:0]][col_q[IW-1:0]] = in_data;
        // Indices wrap to zero on the last element, ready for the next matrix.
        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + DW'(1);
        end else begin
          col_d = col_q + DW'(1);
        end
      end
      S_DONE, S_ERR: if (start) begin
        hdr_cnt_d = '0;
        r1_d      = '0;
        c1_d      = '0;
        r2_d      = '0;
        c2_d      = '0;
        row_d     = '0;
        col_d     = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (rd_sel) begin
      if (DW'(rd_row) < r2_q && DW'(rd_col) < c2_q) rd_data = mat2_q[rd_row][rd_col];
    end else begin
      if (DW'(rd_row) < r1_q && DW'(rd_col) < c1_q) rd_data = mat1_q[rd_row][rd_col];
    end
  end

  assign R1 = r1_q;
  assign C1 = c1_q;
  assign R2 = r2_q;
  assign C2 = c2_q;

endmodule
